// File: rtl/aes_block_serializer_pkg.sv
// rtl/aes_block_serializer_pkg.sv - shared constants and state encoding for the AES block serializer
package aes_block_serializer_pkg;

  localparam int          DATA_WIDTH = 32;
  localparam logic [15:0] LAST_TAG   = 16'h1111;
  localparam logic [15:0] HDR_TAG    = 16'hA5A5;

  // 4 words per 128-bit operand, 16 bytes per block
  localparam int WORD_CNT_W = 2;
  localparam int BYTE_CNT_W = 4;

  localparam logic [WORD_CNT_W-1:0] WORD_LAST = '1;
  localparam logic [BYTE_CNT_W-1:0] BYTE_LAST = '1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD_PT  = 2'd1,
    ST_LOAD_KEY = 2'd2,
    ST_EMIT     = 2'd3
  } state_t;

endpackage

// File: rtl/aes_blk_regfile.sv
// rtl/aes_blk_regfile.sv - 128-bit plaintext and key store, word writes and byte reads
module aes_blk_regfile
  import aes_block_serializer_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  pt_we,
  input  logic                  key_we,
  input  logic [WORD_CNT_W-1:0] wr_idx,
  input  logic [31:0]           wr_data,
  input  logic [BYTE_CNT_W-1:0] rd_idx,
  output logic [7:0]            pt_byte,
  output logic [7:0]            key_byte
);

  logic [127:0] r_pt;
  logic [127:0] r_key;

  // Word n lands in bits [32n+31:32n]; the key is only overwritten by new key words
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pt  <= '0;
      r_key <= '0;
    end else begin
      if (pt_we)  r_pt[{wr_idx, 5'b00000} +: 32]  <= wr_data;
      if (key_we) r_key[{wr_idx, 5'b00000} +: 32] <= wr_data;
    end
  end

  assign pt_byte  = r_pt[{rd_idx, 3'b000} +: 8];
  assign key_byte = r_key[{rd_idx, 3'b000} +: 8];

endmodule

// File: rtl/aes_block_serializer.sv
// rtl/aes_block_serializer.sv - frames host words into blocks and emits one key/data byte pair per write
module aes_block_serializer #(
  parameter int          DATA_WIDTH = aes_block_serializer_pkg::DATA_WIDTH,
  parameter logic [15:0] LAST_TAG   = aes_block_serializer_pkg::LAST_TAG,
  parameter logic [15:0] HDR_TAG    = aes_block_serializer_pkg::HDR_TAG
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_empty,
  output logic                  in_rd,
  input  logic [DATA_WIDTH-1:0] in_din,
  input  logic                  out_full,
  output logic                  out_wr,
  output logic [DATA_WIDTH-1:0] out_dout,
  output logic                  busy,
  output logic [7:0]            err_count
);

  import aes_block_serializer_pkg::*;

  state_t                  r_state;
  logic                    r_reuse;
  logic [WORD_CNT_W-1:0]   r_word;
  logic [BYTE_CNT_W-1:0]   r_byte;
  logic                    r_out_wr;
  logic [DATA_WIDTH-1:0]   r_out_dout;
  logic                    r_busy;
  logic [7:0]              r_err;

  logic                    w_pop;
  logic                    w_pt_we;
  logic                    w_key_we;
  logic [7:0]              w_pt_byte;
  logic [7:0]              w_key_byte;
  logic [15:0]             w_tag;

  // Pops are only offered while loading; the reset term keeps in_rd low during reset
  assign w_pop    = reset_n && !in_empty && (r_state != ST_EMIT);
  assign w_pt_we  = w_pop && (r_state == ST_LOAD_PT);
  assign w_key_we = w_pop && (r_state == ST_LOAD_KEY);
  assign w_tag    = (r_byte == BYTE_LAST) ? LAST_TAG : 16'h0000;

  aes_blk_regfile u_regfile (
    .clock    (clock),
    .reset_n  (reset_n),
    .pt_we    (w_pt_we),
    .key_we   (w_key_we),
    .wr_idx   (r_word),
    .wr_data  (in_din[31:0]),
    .rd_idx   (r_byte),
    .pt_byte  (w_pt_byte),
    .key_byte (w_key_byte)
  );

  // Block framing FSM with registered write strobe, output word, busy and error count
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_reuse    <= 1'b0;
      r_word     <= '0;
      r_byte     <= '0;
      r_out_wr   <= 1'b0;
      r_out_dout <= '0;
      r_busy     <= 1'b0;
      r_err      <= 8'h00;
    end else begin
      r_out_wr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            if (in_din[31:16] == HDR_TAG) begin
              r_reuse <= in_din[0];
              r_word  <= '0;
              r_state <= ST_LOAD_PT;
              r_busy  <= 1'b1;
            end else if (r_err != 8'hFF) begin
              r_err <= r_err + 8'd1;
            end
          end
        end
        ST_LOAD_PT: begin
          if (w_pop) begin
            r_word <= r_word + 2'd1;
            if (r_word == WORD_LAST) begin
              r_byte  <= '0;
              r_state <= r_reuse ? ST_EMIT : ST_LOAD_KEY;
            end
          end
        end
        ST_LOAD_KEY: begin
          if (w_pop) begin
            r_word <= r_word + 2'd1;
            if (r_word == WORD_LAST) begin
              r_byte  <= '0;
              r_state <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          // A full downstream FIFO simply holds the index and the last output word
          if (!out_full) begin
            r_out_wr   <= 1'b1;
            r_out_dout <= {w_tag, w_key_byte, w_pt_byte};
            r_byte     <= r_byte + 4'd1;
            if (r_byte == BYTE_LAST) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign in_rd     = w_pop;
  assign out_wr    = r_out_wr;
  assign out_dout  = r_out_dout;
  assign busy      = r_busy;
  assign err_count = r_err;

endmodule

// File: tb/tb_aes_block_serializer.sv
// tb/tb_aes_block_serializer.sv - scoreboard bench for aes_block_serializer with a byte-level block model
module tb_aes_block_serializer;

  typedef logic [31:0] words_t [4];

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_empty = 1'b1;
  logic        in_rd;
  logic [31:0] in_din = 32'h0;
  logic        out_full = 1'b0;
  logic        out_wr;
  logic [31:0] out_dout;
  logic        busy;
  logic [7:0]  err_count;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          viol = 0;

  logic [31:0] in_q[$];
  logic [31:0] exp_q[$];
  logic [7:0]  m_key[16];
  int          m_err = 0;

  int          empty_mode = 0;
  bit          full_rand = 1'b0;
  int          stall_cnt = 0;
  bit          stall_arm = 1'b0;
  int          blk_byte = 0;
  bit          tog = 1'b0;
  logic        mon_full;

  always #5 clock = ~clock;

  aes_block_serializer dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_empty  (in_empty),
    .in_rd     (in_rd),
    .in_din    (in_din),
    .out_full  (out_full),
    .out_wr    (out_wr),
    .out_dout  (out_dout),
    .busy      (busy),
    .err_count (err_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Host FIFO and downstream-full driver: inputs change on the falling edge, pops are taken just before the rising edge
  initial begin : fifo_drv
    forever begin
      @(negedge clock);
      tog = ~tog;
      if (in_q.size() == 0) begin
        in_empty = 1'b1;
        in_din   = $urandom;
      end else begin
        in_din = in_q[0];
        case (empty_mode)
          0:       in_empty = 1'b0;
          1:       in_empty = tog;
          default: in_empty = ($urandom_range(0, 2) == 0);
        endcase
      end
      if (stall_cnt > 0) begin
        out_full  = 1'b1;
        stall_cnt = stall_cnt - 1;
      end else begin
        out_full = full_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      #4;
      if (in_rd && in_empty) viol++;
      if (in_rd && reset_n && in_q.size() > 0) void'(in_q.pop_front());
    end
  end

  // Output monitor: every write is matched against the next expected word
  always @(posedge clock) begin
    mon_full = out_full;
    #1;
    if (reset_n && out_wr) begin
      if (mon_full) viol++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", out_dout, 32'hxxxxxxxx);
      end else begin
        check($sformatf("out_dout_byte%0d", blk_byte), out_dout, exp_q.pop_front());
      end
      if (stall_arm && blk_byte == 3) begin
        stall_cnt = 5;
        stall_arm = 1'b0;
      end
      blk_byte = (blk_byte + 1) % 16;
    end
  end

  task automatic send_block(input logic [15:0] lo, input words_t pt, input words_t key);
    in_q.push_back({16'hA5A5, lo});
    for (int n = 0; n < 4; n++) in_q.push_back(pt[n]);
    if (!lo[0]) begin
      for (int n = 0; n < 4; n++) begin
        in_q.push_back(key[n]);
        for (int k = 0; k < 4; k++) m_key[4*n+k] = key[n][8*k +: 8];
      end
    end
    for (int i = 0; i < 16; i++)
      exp_q.push_back({(i == 15) ? 16'h1111 : 16'h0000, m_key[i], pt[i/4][8*(i%4) +: 8]});
  endtask

  task automatic send_stray(input logic [31:0] w);
    if (w[31:16] == 16'hA5A5) w[31:16] = 16'h5A5A;
    in_q.push_back(w);
    if (m_err < 255) m_err++;
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0) && c < 3000) begin
      @(posedge clock);
      c++;
    end
    check({tag, "_timeout"}, (c >= 3000), 0);
    repeat (3) @(negedge clock);
    #1;
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err_count"}, err_count, m_err);
    check({tag, "_protocol"}, viol, 0);
  endtask

  function automatic words_t rand_words();
    words_t w;
    for (int n = 0; n < 4; n++) w[n] = $urandom;
    return w;
  endfunction

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    words_t pt;
    words_t key;
    int c;
    for (int i = 0; i < 16; i++) m_key[i] = 8'h00;

    repeat (3) @(negedge clock);
    #1;
    check("rst_out_wr", out_wr, 0);
    check("rst_out_dout", out_dout, 32'h0);
    check("rst_busy", busy, 0);
    check("rst_err_count", err_count, 0);
    check("rst_in_rd", in_rd, 0);
    reset_n = 1'b1;

    // Reference block: bytes 00..0F with key 10..1F
    pt  = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    key = '{32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};
    send_block(16'h0000, pt, key);
    wait_idle("blk_ref");

    // Key reuse with all-FF plaintext
    pt = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    send_block(16'h0001, pt, key);
    wait_idle("blk_reuse");

    // Stray word before a block
    send_stray(32'h12345678);
    send_block(16'h0000, rand_words(), rand_words());
    wait_idle("blk_stray");

    // Downstream stall right after byte 3
    stall_arm = 1'b1;
    send_block(16'h0000, rand_words(), rand_words());
    wait_idle("blk_stall");
    check("stall_consumed", stall_arm, 0);

    // Input FIFO toggling empty every cycle
    empty_mode = 1;
    send_block(16'h0000, rand_words(), rand_words());
    wait_idle("blk_toggle");

    // Randomized traffic
    for (int b = 0; b < 12; b++) begin
      empty_mode = $urandom_range(0, 2);
      full_rand  = $urandom_range(0, 1);
      if ($urandom_range(0, 2) == 0) send_stray($urandom);
      send_block({15'($urandom), 1'($urandom)}, rand_words(), rand_words());
      wait_idle($sformatf("blk_rand%0d", b));
    end

    // Error counter saturation
    empty_mode = 0;
    full_rand  = 1'b0;
    for (int s = 0; s < 260; s++) send_stray($urandom);
    wait_idle("err_sat");

    // Reset in the middle of the emit phase
    send_block(16'h0000, rand_words(), rand_words());
    c = 0;
    while (blk_byte != 8 && c < 500) begin
      @(posedge clock);
      #2;
      c++;
    end
    check("mid_emit_reach_timeout", (c >= 500), 0);
    reset_n = 1'b0;
    #1;
    check("midrst_out_wr", out_wr, 0);
    check("midrst_busy", busy, 0);
    check("midrst_err_count", err_count, 0);
    check("midrst_out_dout", out_dout, 32'h0);
    exp_q.delete();
    in_q.delete();
    m_err = 0;
    blk_byte = 0;
    for (int i = 0; i < 16; i++) m_key[i] = 8'h00;
    in_q.push_back(32'hA5A50000);
    @(negedge clock);
    #2;
    check("midrst_in_rd", in_rd, 0);
    in_q.delete();
    @(negedge clock);
    #1;
    reset_n = 1'b1;

    // After reset: reuse_key sees the cleared key, then a full block
    send_block(16'h0001, rand_words(), rand_words());
    wait_idle("post_rst_zero_key");
    send_block(16'h0000, rand_words(), rand_words());
    wait_idle("post_rst_full");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
